// File: rtl/bcd_scan_mux_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bcd_scan_mux_pkg : shared constants/helpers for scanned BCD displays  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package bcd_scan_mux_pkg;

    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam int         MAX_DIGITS = 8;

    function automatic logic [MAX_DIGITS-1:0] an_all_off(input int num_digits);
        logic [MAX_DIGITS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < num_digits) m[i] = 1'b1;
        end
        return m;
    endfunction

    // $clog2 yields 0 for a range of 1; a zero-width counter is not legal.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_scan_mux_scan_tick_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | scan_tick_gen : free-running prescaler, one tick every PRESCALE clks  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module scan_tick_gen
    import bcd_scan_mux_pkg::*;
#(
    parameter int PRESCALE = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW       = cnt_width(PRESCALE);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_scan_mux.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bcd_scan_mux : frame-synchronous multiplexer of BCD digits to a       |
// | shared 7-segment decoder with active-low anodes. Rev 1.0              |
// +-----------------------------------------------------------------------+
module bcd_scan_mux
    import bcd_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 100000,
    parameter int BLANK_LZ   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int                      PW       = cnt_width(NUM_DIGITS);
    localparam logic [PW-1:0]           POS_LAST = PW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0]   AN_OFF   = NUM_DIGITS'(an_all_off(NUM_DIGITS));
    localparam logic [4*NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{BCD_BLANK}};

    logic                    tick;
    logic                    frame;
    logic                    apply;
    logic                    accept;

    logic [PW-1:0]           pos_q, pos_d;
    logic                    pending_q;
    logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [4*NUM_DIGITS-1:0] sh_dig_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [3:0]              bcd_q, bcd_d;
    logic                    dp_n_q, dp_n_d;
    logic                    fs_q;

    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    zero_run;
    logic [3:0]              sel_digit;
    logic                    sel_blank;
    logic                    sel_dp;

    scan_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign frame     = tick & (pos_q == POS_LAST);
    assign apply     = frame & pending_q;
    assign accept    = upd_valid & ~pending_q;
    assign upd_ready = ~pending_q;

    // Newly applied data is visible on the same edge that selects digit 0.
    assign act_dig_d = apply ? sh_dig_q : act_dig_q;
    assign act_dp_d  = apply ? sh_dp_q  : act_dp_q;

    always_comb begin
        pos_d = pos_q;
        if (tick) begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
        end
    end

    // Walk down from the MSD; a digit blanks while every digit above it is zero.
    always_comb begin
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run      = zero_run & (act_dig_d[4*i +: 4] == 4'h0);
            blank_mask[i] = (BLANK_LZ != 0) & zero_run;
        end
    end

    always_comb begin
        sel_digit = BCD_BLANK;
        sel_blank = 1'b0;
        sel_dp    = 1'b0;
        an_d      = AN_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (pos_d == PW'(i)) begin
                sel_digit = act_dig_d[4*i +: 4];
                sel_blank = blank_mask[i];
                sel_dp    = act_dp_d[i];
                an_d[i]   = 1'b0;
            end
        end
        bcd_d  = sel_blank ? BCD_BLANK : sel_digit;
        dp_n_d = ~sel_dp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q     <= POS_LAST;
            pending_q <= 1'b0;
            act_dig_q <= DIG_OFF;
            act_dp_q  <= '0;
            sh_dig_q  <= '0;
            sh_dp_q   <= '0;
            an_q      <= AN_OFF;
            bcd_q     <= BCD_BLANK;
            dp_n_q    <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            act_dig_q <= act_dig_d;
            act_dp_q  <= act_dp_d;
            fs_q      <= frame;
            if (accept) begin
                sh_dig_q  <= digits_in;
                sh_dp_q   <= dp_in;
                pending_q <= 1'b1;
            end else if (apply) begin
                pending_q <= 1'b0;
            end
            if (tick) begin
                an_q   <= an_d;
                bcd_q  <= bcd_d;
                dp_n_q <= dp_n_d;
            end
        end
    end

    assign an_n        = an_q;
    assign bcd_out     = bcd_q;
    assign dp_n        = dp_n_q;
    assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_mux.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_bcd_scan_mux : randomized bench with a frame-level reference model |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_bcd_scan_mux;

    localparam int N = 4;
    localparam int P = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        upd_valid = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in     = '0;

    logic        a_ready, a_dp, a_fs;
    logic [3:0]  a_bcd, a_an;
    logic        b_ready, b_dp, b_fs;
    logic [3:0]  b_bcd, b_an;

    bcd_scan_mux #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_LZ(1)) dut (
        .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(a_ready),
        .digits_in(digits_in), .dp_in(dp_in), .bcd_out(a_bcd), .an_n(a_an),
        .dp_n(a_dp), .frame_start(a_fs)
    );

    bcd_scan_mux #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(b_ready),
        .digits_in(digits_in), .dp_in(dp_in), .bcd_out(b_bcd), .an_n(b_an),
        .dp_n(b_dp), .frame_start(b_fs)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: edges since reset release, displayed and offered data.
    int          m_n;
    logic        m_pending;
    logic [15:0] m_act, m_sh;
    logic [3:0]  m_dp, m_sh_dp;
    logic [3:0]  e_an, e_bcd_lz, e_bcd_all;
    logic        e_dpn, e_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n       = 0;
        m_pending = 1'b0;
        m_act     = 16'hFFFF;
        m_dp      = '0;
        m_sh      = '0;
        m_sh_dp   = '0;
        e_an      = 4'hF;
        e_bcd_lz  = 4'hF;
        e_bcd_all = 4'hF;
        e_dpn     = 1'b1;
        e_fs      = 1'b0;
    endtask

    // Every P-th edge is a tick; ticks cycle through slots 0..N-1, slot 0 is a frame.
    task automatic model_edge();
        logic ready_before;
        int   ticks, pos;
        ready_before = !m_pending;
        m_n++;
        e_fs = 1'b0;
        if (m_n % P == 0) begin
            ticks = m_n / P;
            pos   = (ticks - 1) % N;
            if (pos == 0 && m_pending) begin
                m_act     = m_sh;
                m_dp      = m_sh_dp;
                m_pending = 1'b0;
            end
            e_fs      = (pos == 0);
            e_an      = ~(4'b0001 << pos);
            e_bcd_all = m_act[4*pos +: 4];
            e_bcd_lz  = (pos > 0 && (m_act >> (4*pos)) == 16'h0) ? 4'hF : e_bcd_all;
            e_dpn     = !m_dp[pos];
        end
        if (upd_valid && ready_before) begin
            m_sh      = digits_in;
            m_sh_dp   = dp_in;
            m_pending = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("an_n",        a_an,    e_an);
        chk("bcd_out",     a_bcd,   e_bcd_lz);
        chk("dp_n",        a_dp,    e_dpn);
        chk("frame_start", a_fs,    e_fs);
        chk("upd_ready",   a_ready, !m_pending);
        chk("nb_an_n",     b_an,    e_an);
        chk("nb_bcd_out",  b_bcd,   e_bcd_all);
        chk("nb_upd_rdy",  b_ready, !m_pending);
    endtask

    task automatic cycle(input logic v, input logic [15:0] d, input logic [3:0] dp);
        upd_valid = v;
        digits_in = d;
        dp_in     = dp;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int k);
        repeat (k) cycle(1'b0, digits_in, dp_in);
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] dp);
        cycle(1'b1, d, dp);
        cycle(1'b0, d, dp);
    endtask

    initial begin
        logic [15:0] rd;
        int          z;

        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        idle(6);
        offer(16'h1234, 4'b0000);
        idle(40);
        offer(16'h0047, 4'b0000);
        idle(40);
        offer(16'h0000, 4'b0000);
        idle(40);
        offer(16'h1111, 4'b0000);
        idle(2);
        offer(16'h2222, 4'b0000);
        idle(40);
        offer(16'h5678, 4'b0100);
        idle(40);

        for (int i = 0; i < 600; i++) begin
            rd = 16'($urandom);
            z  = $urandom_range(0, 4);
            if (z > 0) rd = rd & (16'hFFFF >> (4*z));
            cycle(($urandom_range(0, 5) == 0), rd, 4'($urandom));
        end

        // Asynchronous reset in the middle of a scan with an update pending.
        idle(17);
        offer(16'h9876, 4'b1111);
        idle(3);
        chk("pend_before_rst", a_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_an_n",      a_an,    4'hF);
        chk("rst_bcd_out",   a_bcd,   4'hF);
        chk("rst_dp_n",      a_dp,    1'b1);
        chk("rst_upd_ready", a_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_scan_mux.md
Name: bcd_scan_mux

Overview:
- Time-multiplexes NUM_DIGITS packed BCD digits onto a single shared 7-segment decoder input, and drives active-low digit anodes.
- Sits directly upstream of the BCD-to-7-segment decoder: bcd_out feeds the decoder's 4-bit BCD input, and an_n drives the display common anodes.
- Digit updates arrive through a valid/ready handshake and are applied only at a frame boundary, so no partial frame is ever shown.
- Leading zeros are optionally blanked using code 4'hF, which the decoder renders as all segments off.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- PRESCALE, 100000, clock cycles per digit slot (>=1); 100 MHz gives 1 kHz per digit.
- BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- upd_valid  in  1  new digit/dp data offered.
- upd_ready  out  1  block can accept an update.
- digits_in  in  4*NUM_DIGITS  packed BCD; [3:0] = digit 0 (LSD).
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = on.
- bcd_out  out  4  BCD code of the currently selected digit, to the decoder.
- an_n  out  NUM_DIGITS  anode enables, active-low, one-hot-low while scanning.
- dp_n  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when digit 0 is selected.

Behaviour:
- One clock domain. Reset is asynchronous and active-low; all state is cleared immediately on assertion.
- Reset values:
  - an_n all 1s, bcd_out 4'hF, dp_n 1, frame_start 0, upd_ready 1.
  - Prescale counter 0; scan position NUM_DIGITS-1.
  - Active digit registers all 4'hF; active dp all 0; shadow registers cleared; pending 0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick is asserted in the cycle where count == PRESCALE-1.
  - With PRESCALE=1, tick is asserted every cycle.
- Scan position:
  - On tick, advances by 1 and wraps NUM_DIGITS-1 -> 0.
  - The first tick after reset selects digit 0.
- Output registers (an_n, bcd_out, dp_n):
  - Update on the same edge the position changes and reflect the new position.
  - They hold constant between ticks.
  - Until the first tick after reset, all anodes are off.
- Frame boundary = a tick whose next position is 0. On that edge:
  - frame_start pulses for exactly 1 cycle.
  - If pending=1: active registers <= shadow, and pending <= 0. Digit 0 is driven from the newly applied data on that same edge.
- Handshake:
  - upd_ready = ~pending.
  - When upd_valid & upd_ready on a clk edge: shadow <= digits_in and dp_in; pending <= 1.
  - upd_valid while upd_ready=0 is ignored; nothing is captured and the upstream block must hold or retry.
  - upd_ready rises in the cycle after the frame boundary that applied the data.
  - Accept and apply can never coincide, because ready=0 whenever pending=1.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i (i>0) is blanked when the active digits i..NUM_DIGITS-1 are all 4'h0.
  - Digit 0 is never blanked.
  - A blanked digit drives bcd_out=4'hF; its anode is still asserted.
- dp_n = ~active_dp[position], independent of blanking.
- Digit values 4'hA..4'hF are passed through unchanged; the decoder blanks them.
- Reset mid-frame: outputs return to reset values asynchronously, and any pending update is discarded.

Decomposition:
- Shared package:
  - BCD_BLANK = 4'hF.
  - AN_ALL_OFF helper, as a function of NUM_DIGITS.
  - Counter width = $clog2(PRESCALE) (minimum 1).
- One sub-module, scan_tick_gen:
  - Parameter PRESCALE; inputs clk, rst_n; output tick.
  - Reused by any other scanned display.
- Blanking mask and the handshake/shadow logic stay in bcd_scan_mux.

Test Plan:
- All tests use NUM_DIGITS=4, PRESCALE=4.
- Reset -> an_n=4'b1111, bcd_out=4'hF, dp_n=1, upd_ready=1. At the first tick (cycle 4 after release): an_n=4'b1110, bcd_out=4'hF, frame_start=1 for one cycle.
- upd_valid pulse with digits_in=16'h1234, issued mid-frame -> upd_ready=0 and the display is unchanged until the next frame_start. Then an_n steps 1110/1101/1011/0111 with bcd_out 4/3/2/1, 4 cycles each. upd_ready=1 from the cycle after that frame_start.
- BLANK_LZ=1, load 16'h0047 -> digits 3 and 2 show bcd_out=4'hF with anodes still low. Load 16'h0000 -> only digit 0 shows 0. With BLANK_LZ=0, 16'h0047 shows 0,0,4,7.
- Load 16'h1111 and, while upd_ready=0, pulse upd_valid with 16'h2222 -> the second offer is ignored; the next frame displays 1111.
- dp_in=4'b0100 with 16'h5678 -> dp_n=0 only while an_n=4'b1011 (bcd_out=6), and 1 on all other slots.
- Assert rst_n low mid-scan with an update pending -> immediately an_n=4'b1111, bcd_out=4'hF, upd_ready=1. After release the display is blank (pending was discarded).
